psum_drain_arbiter: RTL
=======================

Name: psum_drain_arbiter

Overview:
Parametrised output-drain stage for the PE array. It collects partial-sum results from NUM_CH array rows, each accompanied by a valid strobe, into per-channel FIFOs. A round-robin arbiter drains the FIFOs into a single requantised OUT_W-bit stream with a valid/ready handshake. It replaces the fixed single-row select and ±127 clamp with per-channel buffering, a right-shift requantiser, optional ReLU, and saturation/overflow statistics.

Parameters:
NUM_CH, 3, number of psum input channels (array rows), >=2
PSUM_W, 10, signed psum width per channel
OUT_W, 8, signed output width, OUT_W <= PSUM_W
FIFO_DEPTH, 4, entries per channel FIFO, power of two >=2
SHIFT_W, 3, width of requantisation shift control

Ports:
clk  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
clear_i  in  1  synchronous flush of all state, same effect as reset
psum_i  in  NUM_CH*PSUM_W  channel c occupies bits [c*PSUM_W +: PSUM_W], two's complement
psum_valid_i  in  NUM_CH  per-channel push strobe
ch_full_o  out  NUM_CH  per-channel FIFO full (combinational from occupancy)
shift_i  in  SHIFT_W  arithmetic right-shift amount applied before saturation
relu_en_i  in  1  when 1, negative results output as 0
out_valid_o  out  1  output data valid
out_ready_i  in  1  downstream accept
out_data_o  out  OUT_W  requantised, saturated result
out_ch_o  out  max(1,$clog2(NUM_CH))  source channel of out_data_o
sat_count_o  out  16  number of outputs that saturated
overflow_o  out  NUM_CH  sticky per-channel dropped-push flag

Behaviour:
- Reset (nRST=0, async) or clear_i=1 (sync, highest priority): all FIFOs empty, RR pointer=0, out_valid_o=0, out_data_o=0, out_ch_o=0, sat_count_o=0, overflow_o=0. Pushes and transfers in a clear cycle are discarded.
- Push: on channel c with psum_valid_i[c]=1, accept if FIFO not full, or if full and the same cycle pops channel c. Otherwise drop the value and set overflow_o[c]=1. The flag stays set until reset or clear.
- Output register: loads when any FIFO is non-empty and (out_valid_o=0 or out_ready_i=1). This pops the granted FIFO. If no FIFO is non-empty and out_ready_i=1, out_valid_o goes to 0.
- out_data_o and out_ch_o hold stable while out_valid_o=1 and out_ready_i=0.
- Latency: psum_valid_i sampled at edge k -> out_valid_o=1 after edge k+1, with an idle output and no contention.
- Throughput: one output per cycle while out_ready_i=1.
- Arbiter:
  - Grant the lowest channel index >= pointer whose FIFO is non-empty, wrapping past NUM_CH-1 to 0.
  - On each load, pointer = grant+1 modulo NUM_CH.
  - Arbitration uses occupancy before same-cycle pushes. An empty FIFO pushed this cycle is not eligible until the next cycle (no bypass).
- Requantisation, combinational on the FIFO head at load:
  - s = head >>> shift_i, sign-extended.
  - If relu_en_i and s<0, then s=0.
  - Saturate to the symmetric range [-(2^(OUT_W-1)-1), +(2^(OUT_W-1)-1)], i.e. ±127 for OUT_W=8; the most-negative code is never produced.
  - If clamping occurred, sat_count_o increments on that load, sticking at 0xFFFF. ReLU zeroing is not counted as saturation.
  - shift_i and relu_en_i are sampled at load time; changing them mid-stream affects only subsequent loads.
- FIFO full/empty from a pointer-plus-count implementation; full when count=FIFO_DEPTH.
- Order within a channel is strictly preserved.

Test Plan:
- Reset: nRST=0 mid-stream with 3 entries buffered -> immediately out_valid_o=0, sat_count_o=0, overflow_o=0; after release, no stale data emerges.
- Single path: ch1 push 10'sd45, shift=0, relu=0, ready=1 -> two edges later out_valid_o=1, out_data_o=45, out_ch_o=1, for one cycle.
- Round robin: all 3 channels push together (ch0=1, ch1=2, ch2=3), ready=1 -> outputs on consecutive cycles: ch0/1, ch1/2, ch2/3. Repeat with pointer at 2 -> order ch2, ch0, ch1.
- Saturation and shift:
  - push 300, shift=0 -> out 127, sat_count_o=1.
  - push -300 -> out -127, sat_count_o=2.
  - push 300, shift=2 -> out 75, sat_count_o unchanged.
  - push -20 with relu=1 -> out 0, sat_count_o unchanged.
- Backpressure/overflow: ready=0, 6 pushes on ch0 (FIFO_DEPTH=4) -> register holds 1st value, FIFO holds 4, ch_full_o[0]=1, 6th push dropped, overflow_o[0]=1. Raise ready -> exactly 5 values out, in order.
- Full with simultaneous push/pop: ch0 full, ready=1 with a push in the same cycle -> push accepted, overflow_o stays 0. clear_i pulse afterwards -> all empty, counters 0.

Source files
------------

// File: rtl/psum_drain_arbiter.sv
// Output drain for the PE array: per-row psum FIFOs, round-robin arbitration,
// shift/ReLU/saturate requantisation into one valid/ready stream with statistics.
module psum_drain_arbiter #(
    parameter int NUM_CH     = 3,
    parameter int PSUM_W     = 10,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SHIFT_W    = 3,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic                       clear_i,
    input  logic [NUM_CH*PSUM_W-1:0]   psum_i,
    input  logic [NUM_CH-1:0]          psum_valid_i,
    output logic [NUM_CH-1:0]          ch_full_o,
    input  logic [SHIFT_W-1:0]         shift_i,
    input  logic                       relu_en_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [OUT_W-1:0]           out_data_o,
    output logic [CH_W-1:0]            out_ch_o,
    output logic [15:0]                sat_count_o,
    output logic [NUM_CH-1:0]          overflow_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic signed [PSUM_W-1:0] SAT_POS = PSUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PSUM_W-1:0] SAT_NEG = -SAT_POS;

    logic [NUM_CH-1:0] not_empty;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] push_ok;
    logic [PSUM_W-1:0] head [NUM_CH];

    logic              grant_valid;
    logic [CH_W-1:0]   grant;
    logic              load;

    logic [CH_W-1:0]   rr_ptr_reg;
    logic              out_valid_reg;
    logic [OUT_W-1:0]  out_data_reg;
    logic [CH_W-1:0]   out_ch_reg;
    logic [15:0]       sat_count_reg;

    // Per-channel FIFO: pointer-plus-count, head read combinationally so a
    // freshly written entry can load on the very next edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [PSUM_W-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [CNT_W-1:0]  cnt_reg;
            logic              overflow_reg;
            logic [PSUM_W-1:0] din;

            assign din           = psum_i[gi*PSUM_W +: PSUM_W];
            assign not_empty[gi] = (cnt_reg != '0);
            assign ch_full_o[gi] = (cnt_reg == CNT_W'(FIFO_DEPTH));
            assign pop[gi]       = load && (grant == CH_W'(gi));
            // A full FIFO still accepts when the same edge pops it.
            assign push_ok[gi]   = psum_valid_i[gi] && (!ch_full_o[gi] || pop[gi]);
            assign head[gi]      = mem[rd_ptr_reg];
            assign overflow_o[gi] = overflow_reg;

            always_ff @(posedge clk) begin
                if (push_ok[gi] && !clear_i) begin
                    mem[wr_ptr_reg] <= din;
                end
            end

            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    cnt_reg      <= '0;
                    overflow_reg <= 1'b0;
                end else if (clear_i) begin
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    cnt_reg      <= '0;
                    overflow_reg <= 1'b0;
                end else begin
                    if (push_ok[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    unique case ({push_ok[gi], pop[gi]})
                        2'b10:   cnt_reg <= cnt_reg + 1'b1;
                        2'b01:   cnt_reg <= cnt_reg - 1'b1;
                        default: cnt_reg <= cnt_reg;
                    endcase
                    if (psum_valid_i[gi] && !push_ok[gi]) begin
                        overflow_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Round-robin search starting at the pointer, on pre-push occupancy.
    always_comb begin
        logic [CH_W:0] idx_sum;
        grant_valid = 1'b0;
        grant       = '0;
        idx_sum     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_sum = {1'b0, rr_ptr_reg} + (CH_W+1)'(i);
            if (idx_sum >= (CH_W+1)'(NUM_CH)) begin
                idx_sum = idx_sum - (CH_W+1)'(NUM_CH);
            end
            if (!grant_valid && not_empty[idx_sum[CH_W-1:0]]) begin
                grant_valid = 1'b1;
                grant       = idx_sum[CH_W-1:0];
            end
        end
    end

    assign load = grant_valid && (!out_valid_reg || out_ready_i);

    logic signed [PSUM_W-1:0] sel_head;
    logic signed [PSUM_W-1:0] shifted;
    logic signed [PSUM_W-1:0] relued;
    logic signed [PSUM_W-1:0] clamped;
    logic                     sat_hit;

    // Symmetric clamp: the most-negative OUT_W code is never emitted.
    always_comb begin
        sel_head = $signed(head[grant]);
        shifted  = sel_head >>> shift_i;
        relued   = (relu_en_i && shifted[PSUM_W-1]) ? '0 : shifted;
        sat_hit  = 1'b0;
        clamped  = relued;
        if (relued > SAT_POS) begin
            clamped = SAT_POS;
            sat_hit = 1'b1;
        end else if (relued < SAT_NEG) begin
            clamped = SAT_NEG;
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            sat_count_reg <= '0;
        end else if (clear_i) begin
            rr_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            sat_count_reg <= '0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= OUT_W'(clamped);
            out_ch_reg    <= grant;
            rr_ptr_reg    <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            if (sat_hit && (sat_count_reg != 16'hFFFF)) begin
                sat_count_reg <= sat_count_reg + 1'b1;
            end
        end else if (out_ready_i) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_reg;
    assign out_data_o  = out_data_reg;
    assign out_ch_o    = out_ch_reg;
    assign sat_count_o = sat_count_reg;

endmodule
